// File: rtl/iss_sample_sequencer.sv
`timescale 1ns/1ps
// iss_sample_sequencer: interrogate-driven fine/coarse resolver sample sequencer
// with reference-edge watchdog window, overrun flag and interrogate counter.
module iss_sample_sequencer #(
   parameter int SETTLE_CYC = 8,
   parameter int GAP_CYC    = 4,
   parameter int WDOG_CYC   = 400
) (
   input  logic       CLOCKH,
   input  logic       rst_n,
   input  logic       ISSIHI,
   input  logic       UREF1H,
   output logic       RDCYCL,
   output logic       SMPLF,
   output logic       SMPLC,
   output logic       PHASE,
   output logic       OVRN,
   output logic       ISSFLT,
   output logic [7:0] INTCNT
);

   localparam int CW = 16;
   localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
   localparam logic [CW-1:0] GAP_LD    = CW'(GAP_CYC - 1);
   localparam logic [9:0]    WDOG_LD   = 10'(WDOG_CYC);

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      SAMPF,
      GAP,
      SAMPC
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_nxt;
   logic          accept;

   logic [2:0]    iss_sy;
   logic [2:0]    ref_sy;
   logic          irq_ev;
   logic          ref_ev;

   logic          phase_q;
   logic          ovrn_q;
   logic          flt_q;
   logic [7:0]    intcnt_q;

   logic          win_open;
   logic [9:0]    wd_tmr;
   logic [1:0]    good;
   logic          in_win;
   logic          miss;

   // [0],[1] form the synchronizer; [2] is the edge-detect history
   always_ff @(posedge CLOCKH) begin
      if (!rst_n) begin
         iss_sy <= '0;
         ref_sy <= '0;
      end else begin
         iss_sy <= {iss_sy[1:0], ISSIHI};
         ref_sy <= {ref_sy[1:0], UREF1H};
      end
   end

   assign irq_ev = iss_sy[1] & ~iss_sy[2];
   assign ref_ev = ref_sy[1] ^ ref_sy[2];

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      unique case (state)
         IDLE: begin
            if (irq_ev) begin
               state_nxt = SETTLE;
               cnt_nxt   = SETTLE_LD;
               accept    = 1'b1;
            end
         end
         SETTLE: begin
            if (cnt == '0) begin
               state_nxt = SAMPF;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         SAMPF: begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LD;
         end
         GAP: begin
            if (cnt == '0) begin
               state_nxt = SAMPC;
            end else begin
               cnt_nxt = cnt - CW'(1);
            end
         end
         SAMPC: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLOCKH) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge CLOCKH) begin
      if (!rst_n) begin
         phase_q  <= 1'b0;
         ovrn_q   <= 1'b0;
         intcnt_q <= '0;
      end else begin
         ovrn_q <= irq_ev && (state != IDLE);
         if (accept) begin
            intcnt_q <= intcnt_q + 8'd1;
         end
         if (state == SETTLE && state_nxt == SAMPF) begin
            phase_q <= ref_sy[1];
         end
      end
   end

   // an interrogate coincident with a reference edge belongs to the old window
   assign in_win = irq_ev & win_open;
   assign miss   = win_open & ~irq_ev & (ref_ev | (wd_tmr <= 10'd1));

   always_ff @(posedge CLOCKH) begin
      if (!rst_n) begin
         win_open <= 1'b0;
         wd_tmr   <= '0;
         good     <= '0;
         flt_q    <= 1'b0;
      end else begin
         if (ref_ev) begin
            win_open <= 1'b1;
            wd_tmr   <= WDOG_LD;
         end else if (in_win || miss) begin
            win_open <= 1'b0;
            wd_tmr   <= '0;
         end else if (win_open) begin
            wd_tmr <= wd_tmr - 10'd1;
         end

         if (miss) begin
            flt_q <= 1'b1;
            good  <= '0;
         end else if (in_win) begin
            if (good != 2'd2) begin
               good <= good + 2'd1;
            end
            if (good != 2'd0) begin
               flt_q <= 1'b0;
            end
         end
      end
   end

   assign RDCYCL = (state != IDLE);
   assign SMPLF  = (state == SAMPF);
   assign SMPLC  = (state == SAMPC);
   assign PHASE  = phase_q;
   assign OVRN   = ovrn_q;
   assign ISSFLT = flt_q;
   assign INTCNT = intcnt_q;

endmodule

// File: tb/tb_iss_sample_sequencer.sv
`timescale 1ns/1ps
// tb_iss_sample_sequencer: directed and random stimulus checked each cycle
// against an edge-indexed reference model.
module tb_iss_sample_sequencer;

   localparam int SETTLE = 8;
   localparam int GAP    = 4;
   localparam int WDOG   = 400;
   localparam int LAST   = SETTLE + GAP + 1;
   localparam int MAXE   = 16384;

   logic       CLOCKH = 1'b0;
   logic       rst_n  = 1'b0;
   logic       ISSIHI = 1'b0;
   logic       UREF1H = 1'b0;
   logic       RDCYCL;
   logic       SMPLF;
   logic       SMPLC;
   logic       PHASE;
   logic       OVRN;
   logic       ISSFLT;
   logic [7:0] INTCNT;

   int checks = 0;
   int errors = 0;

   iss_sample_sequencer #(
      .SETTLE_CYC(SETTLE),
      .GAP_CYC   (GAP),
      .WDOG_CYC  (WDOG)
   ) dut (
      .CLOCKH(CLOCKH),
      .rst_n (rst_n),
      .ISSIHI(ISSIHI),
      .UREF1H(UREF1H),
      .RDCYCL(RDCYCL),
      .SMPLF (SMPLF),
      .SMPLC (SMPLC),
      .PHASE (PHASE),
      .OVRN  (OVRN),
      .ISSFLT(ISSFLT),
      .INTCNT(INTCNT)
   );

   always #5 CLOCKH = ~CLOCKH;

   // model: inputs sampled at each edge n; acceptance edge t0; window deadline
   bit iss_h[MAXE];
   bit ref_h[MAXE];
   int n       = 2;
   int t0      = -1000;
   int m_dl    = 0;
   int m_good  = 0;
   int m_cnt   = 0;
   bit m_open  = 1'b0;
   bit m_flt   = 1'b0;
   bit m_phase = 1'b0;
   bit m_ovrn  = 1'b0;
   bit cur_uref = 1'b0;
   int ovrn_seen = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d edge %0d", tag, got, exp, n);
      end
   endtask

   function automatic bit in_read(input int e);
      return (e >= t0) && (e <= t0 + LAST);
   endfunction

   task automatic model_edge(input bit iss, input bit uref, input bit rst);
      bit irq;
      bit rev;
      bit inw;
      bit mis;
      n++;
      if (n >= MAXE) begin
         $display("FAIL budget edge %0d exceeds %0d", n, MAXE);
         $fatal(1, "edge budget exhausted");
      end
      iss_h[n] = iss;
      ref_h[n] = uref;
      if (rst) begin
         iss_h[n] = 0; iss_h[n-1] = 0; iss_h[n-2] = 0;
         ref_h[n] = 0; ref_h[n-1] = 0; ref_h[n-2] = 0;
         t0 = -1000;
         m_cnt = 0; m_phase = 0; m_ovrn = 0;
         m_flt = 0; m_good = 0; m_open = 0;
         return;
      end
      irq = iss_h[n-2] && !iss_h[n-3];
      rev = ref_h[n-2] != ref_h[n-3];
      m_ovrn = 0;
      if (irq) begin
         if (in_read(n - 1)) begin
            m_ovrn = 1;
         end else begin
            t0 = n;
            m_cnt = (m_cnt + 1) % 256;
         end
      end
      if (n == t0 + SETTLE) m_phase = ref_h[n-2];
      inw = irq && m_open;
      mis = m_open && !irq && (rev || n == m_dl);
      if (mis) begin
         m_flt = 1;
         m_good = 0;
      end else if (inw) begin
         m_good++;
         if (m_good >= 2) m_flt = 0;
      end
      if (rev) begin
         m_open = 1;
         m_dl = n + WDOG;
      end else if (inw || mis) begin
         m_open = 0;
      end
   endtask

   task automatic cmp_all();
      check("rdcycl", RDCYCL, in_read(n));
      check("smplf", SMPLF, n == t0 + SETTLE);
      check("smplc", SMPLC, n == t0 + LAST);
      check("phase", PHASE, m_phase);
      check("ovrn", OVRN, m_ovrn);
      check("issflt", ISSFLT, m_flt);
      check("intcnt", INTCNT, m_cnt);
   endtask

   task automatic step(input bit iss, input bit rst);
      @(negedge CLOCKH);
      ISSIHI = iss;
      UREF1H = cur_uref;
      rst_n  = !rst;
      @(posedge CLOCKH);
      model_edge(iss, cur_uref, rst);
      #1;
      if (OVRN === 1'b1) ovrn_seen++;
      cmp_all();
   endtask

   task automatic idle(input int c);
      for (int i = 0; i < c; i++) step(1'b0, 1'b0);
   endtask

   task automatic pulse(input int hi);
      for (int i = 0; i < hi; i++) step(1'b1, 1'b0);
   endtask

   task automatic do_reset(input int c);
      for (int i = 0; i < c; i++) step(1'b0, 1'b1);
   endtask

   initial begin
      bit iss_r;
      do_reset(4);
      check("rst_rdcycl", RDCYCL, 0);
      check("rst_intcnt", INTCNT, 0);

      // single interrogate
      idle(5);
      pulse(3);
      idle(30);
      check("single_cnt", INTCNT, 1);

      // overrun: second pulse starts 5 cycles after the first
      ovrn_seen = 0;
      pulse(3);
      idle(2);
      pulse(2);
      idle(30);
      check("ovrn_once", ovrn_seen, 1);
      check("ovrn_cnt", INTCNT, 2);

      // watchdog expiry then recovery
      cur_uref = 1'b1;
      idle(450);
      check("wdog_set", ISSFLT, 1);
      cur_uref = 1'b0;
      idle(10);
      pulse(3);
      idle(20);
      check("wdog_hold", ISSFLT, 1);
      cur_uref = 1'b1;
      idle(10);
      pulse(3);
      idle(20);
      check("wdog_clr", ISSFLT, 0);

      // back-to-back reference edges
      cur_uref = 1'b0;
      idle(200);
      cur_uref = 1'b1;
      idle(4);
      check("b2b_flt", ISSFLT, 1);
      idle(20);

      // phase capture
      cur_uref = 1'b1;
      idle(5);
      pulse(2);
      idle(20);
      check("phase_hi", PHASE, 1);
      cur_uref = 1'b0;
      idle(5);
      pulse(2);
      idle(20);
      check("phase_lo", PHASE, 0);

      // random traffic
      iss_r = 1'b0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 39) == 0) cur_uref = ~cur_uref;
         if ($urandom_range(0, 7) == 0) iss_r = ~iss_r;
         step(iss_r, $urandom_range(0, 499) == 0);
      end

      // counter wrap
      do_reset(2);
      for (int i = 0; i < 256; i++) begin
         pulse(2);
         idle(16);
      end
      check("wrap", INTCNT, 0);

      // reset during GAP aborts the cycle
      pulse(2);
      idle(11);
      check("in_gap", RDCYCL, 1);
      do_reset(1);
      check("abort_rd", RDCYCL, 0);
      check("abort_smplc", SMPLC, 0);
      idle(10);

      // interrogate held high across reset release
      step(1'b1, 1'b1);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      check("rel_wait", RDCYCL, 0);
      step(1'b1, 1'b0);
      check("rel_evt", RDCYCL, 1);
      idle(20);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
